// File: rtl/mul_ha_accum_ctrl_if.sv
// ----------------------------------------------------------------------------
// mul_ha_accum_ctrl_if
// Operand/result handshake bundle for mul_ha_accum_ctrl.
//
// Signals:
//   in_valid    : operand pair offered by the producer
//   in_ready    : controller can accept an operand pair
//   in_x, in_y  : 8-bit operands
//   out_valid   : product available
//   out_ready   : consumer accepts the product
//   out_product : 16-bit (saturated) product
//
// Modports:
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : controller side (drives in_ready, out_valid, out_product)
// ----------------------------------------------------------------------------
interface mul_ha_accum_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/mul_ha_accum_ctrl.sv
// ----------------------------------------------------------------------------
// mul_ha_accum_ctrl
// Sequencing controller for an external approximate 8x8 ha_array multiplier.
// It latches an operand pair, presents it on x/y, then accumulates the four
// combinational row outputs of the multiplier (one row per cycle, each row
// weighted by 4^k) into a 17-bit accumulator and returns a saturated 16-bit
// product.
//
// Ports:
//   clk                      : clock, rising edge
//   rst                      : synchronous, active-high reset
//   bus (slave)              : in_valid/in_ready/in_x/in_y operand handshake,
//                              out_valid/out_ready/out_product result handshake
//   x, y                     : registered operands to the multiplier
//   ha_array_k_b (7b), ha_array_k_t (9b), k = 0..3 : multiplier row outputs
//   busy                     : controller is not idle
//   op_count                 : completed results, wraps modulo 2^16
//   state_dbg_o              : current FSM state (IDLE=0, ACC=1, DONE=2)
//
// Build option:
//   MUL_HA_BIAS_COMP_EN : when defined, 224 is added to the accumulator on
//                         DONE entry to compensate the multiplier's mean
//                         approximation error.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds valid and data stable until that edge, and the
// receiver may not make ready depend on anything but its own state.
// ----------------------------------------------------------------------------
module mul_ha_accum_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  mul_ha_accum_ctrl_if.slave   bus,
  output logic [7:0]           x,
  output logic [7:0]           y,
  input  logic [6:0]           ha_array_0_b,
  input  logic [8:0]           ha_array_0_t,
  input  logic [6:0]           ha_array_1_b,
  input  logic [8:0]           ha_array_1_t,
  input  logic [6:0]           ha_array_2_b,
  input  logic [8:0]           ha_array_2_t,
  input  logic [6:0]           ha_array_3_b,
  input  logic [8:0]           ha_array_3_t,
  output logic                 busy,
  output logic [15:0]          op_count,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef MUL_HA_BIAS_COMP_EN
  localparam logic [16:0] BIAS = 17'd224;
`else
  localparam logic [16:0] BIAS = 17'd0;
`endif

  state_e      state_q;
  logic [7:0]  x_q, y_q;
  logic [16:0] acc_q;
  logic [2:0]  row_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [15:0] out_product_q;
  logic        busy_q;
  logic [15:0] op_count_q;

  logic [8:0]  row_t;
  logic [6:0]  row_b;
  logic [9:0]  row_val;
  logic [16:0] row_shifted;
  logic [16:0] acc_d;
  logic [16:0] final_sum;
  logic [15:0] product_d;
  logic [15:0] op_count_d;

  // Row select, weighting and saturation. row_q counts 0..3 for the four
  // accumulate cycles; row_q == 4 is the DONE-registration cycle.
  always_comb begin
    row_t = 9'd0;
    row_b = 7'd0;
    case (row_q[1:0])
      2'd0: begin row_t = ha_array_0_t; row_b = ha_array_0_b; end
      2'd1: begin row_t = ha_array_1_t; row_b = ha_array_1_b; end
      2'd2: begin row_t = ha_array_2_t; row_b = ha_array_2_b; end
      default: begin row_t = ha_array_3_t; row_b = ha_array_3_b; end
    endcase
    row_val     = {1'b0, row_t} + {1'b0, row_b, 2'b00};
    row_shifted = {7'd0, row_val} << {row_q[1:0], 1'b0};
    acc_d       = acc_q + row_shifted;
    // Max accumulator is 1019*85 = 86615, so adding the bias cannot wrap.
    final_sum   = acc_q + BIAS;
    product_d   = final_sum[16] ? 16'hFFFF : final_sum[15:0];
    op_count_d  = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= 8'd0;
      y_q           <= 8'd0;
      acc_q         <= 17'd0;
      row_q         <= 3'd0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_product_q <= 16'd0;
      busy_q        <= 1'b0;
      op_count_q    <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.in_x;
            y_q        <= bus.in_y;
            acc_q      <= 17'd0;
            row_q      <= 3'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACC;
          end
        end
        ACC: begin
          if (row_q == 3'd4) begin
            out_product_q <= product_d;
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            acc_q <= acc_d;
            row_q <= row_q + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign x               = x_q;
  assign y               = y_q;
  assign busy            = busy_q;
  assign op_count        = op_count_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_mul_ha_accum_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mul_ha_accum_ctrl
// Bench for mul_ha_accum_ctrl. The external multiplier is modelled as an
// exact 8x8 multiplier split into four 2-bit-digit rows, so the expected
// product is simply x*y (+bias). Rows can also be overridden with fixed
// values to exercise the row arithmetic and saturation directly.
// ----------------------------------------------------------------------------
module tb_mul_ha_accum_ctrl;

`ifdef MUL_HA_BIAS_COMP_EN
  localparam int BIAS = 224;
`else
  localparam int BIAS = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_ha_accum_ctrl_if bus ();

  logic [7:0]  x, y;
  logic [8:0]  tt [4];
  logic [6:0]  bb [4];
  logic        busy;
  logic [15:0] op_count;
  logic [1:0]  state_dbg;

  mul_ha_accum_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .x            (x),
    .y            (y),
    .ha_array_0_b (bb[0]),
    .ha_array_0_t (tt[0]),
    .ha_array_1_b (bb[1]),
    .ha_array_1_t (tt[1]),
    .ha_array_2_b (bb[2]),
    .ha_array_2_t (tt[2]),
    .ha_array_3_b (bb[3]),
    .ha_array_3_t (tt[3]),
    .busy         (busy),
    .op_count     (op_count),
    .state_dbg_o  (state_dbg)
  );

  // external multiplier model
  logic       force_rows;
  logic [8:0] ft [4];
  logic [6:0] fb [4];

  // Row k is x times base-4 digit k of y, split into t + 4*b.
  function automatic logic [15:0] row_model(input logic [7:0] a, input logic [1:0] d);
    int p, bq, tq;
    p  = int'(a) * int'(d);
    bq = p / 4;
    if (bq > 127) bq = 127;
    tq = p - bq * 4;
    return {bq[6:0], tq[8:0]};
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (force_rows) begin
        tt[k] = ft[k];
        bb[k] = fb[k];
      end else begin
        {bb[k], tt[k]} = row_model(x, y[2*k +: 2]);
      end
    end
  end

  // reference model
  function automatic logic [15:0] sat16(input int s);
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] exp_mul(input logic [7:0] a, input logic [7:0] b);
    return sat16(int'(a) * int'(b) + BIAS);
  endfunction

  function automatic logic [15:0] exp_rows();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += (int'(ft[k]) + 4 * int'(fb[k])) * (1 << (2 * k));
    return sat16(s + BIAS);
  endfunction

  // scoreboard
  logic [15:0] exp_q [$];
  logic [15:0] exp_count;
  int          n_checks = 0;
  int          n_pass   = 0;

  // driver tasks: all start and end just after a falling edge
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_x = 8'd0; bus.in_y = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_count = 16'd0;
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    bus.in_valid = 1'b1; bus.in_x = a; bus.in_y = b;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns cycles from transfer edge to out_valid (0 if never seen).
  task automatic wait_valid(input bit noise, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (noise) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.in_x      = 8'($urandom_range(0, 255));
        bus.in_y      = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_count = exp_count + 16'd1;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_product !== 16'h0) $display("FAIL reset_out_product: got %h want 0", bus.out_product); else n_pass++;
    n_checks++; if (x !== 8'h0) $display("FAIL reset_x: got %h want 0", x); else n_pass++;
    n_checks++; if (y !== 8'h0) $display("FAIL reset_y: got %h want 0", y); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (op_count !== 16'h0) $display("FAIL reset_op_count: got %h want 0", op_count); else n_pass++;
  endtask

  task automatic test_zero();
    int lat;
    logic [15:0] e;
    force_rows = 1'b0;
    send(8'd0, 8'd0, exp_mul(8'd0, 8'd0));
    wait_valid(1'b0, lat);
    n_checks++; if (lat != 5) $display("FAIL zero_latency: got %0d want 5", lat); else n_pass++;
    e = exp_q.pop_front();
    n_checks++; if (bus.out_product !== e) $display("FAIL zero_product: got %h want %h", bus.out_product, e); else n_pass++;
    accept();
    n_checks++; if (op_count !== exp_count) $display("FAIL zero_op_count: got %h want %h", op_count, exp_count); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL zero_in_ready_after: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] a, b;
    logic [15:0] e;
    force_rows = 1'b0;
    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (n == 0) begin a = 8'hFF; b = 8'hFF; end
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rand_in_ready: got %b want 1", bus.in_ready); else n_pass++;
      send(a, b, exp_mul(a, b));
      n_checks++; if (x !== a || y !== b) $display("FAIL rand_xy_latch: got %h/%h want %h/%h", x, y, a, b); else n_pass++;
      wait_valid(1'b1, lat);
      n_checks++; if (lat != 5) $display("FAIL rand_latency: got %0d want 5", lat); else n_pass++;
      n_checks++; if (x !== a || y !== b) $display("FAIL rand_xy_hold: got %h/%h want %h/%h", x, y, a, b); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (bus.out_product !== e) $display("FAIL rand_product: %h*%h got %h want %h", a, b, bus.out_product, e); else n_pass++;
      accept();
      n_checks++; if (op_count !== exp_count) $display("FAIL rand_op_count: got %h want %h", op_count, exp_count); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rand_busy_idle: got %b want 0", busy); else n_pass++;
    end
  endtask

  task automatic test_rows_edge();
    int lat;
    logic [15:0] e;
    force_rows = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 4; k++) begin
        case (n)
          0: begin ft[k] = (k == 0) ? 9'h1FF : 9'h0; fb[k] = (k == 3) ? 7'h7F : 7'h0; end
          1: begin ft[k] = 9'h1FF; fb[k] = 7'h7F; end
          default: begin ft[k] = 9'($urandom_range(0, 511)); fb[k] = 7'($urandom_range(0, 127)); end
        endcase
      end
      e = exp_rows();
      if (n == 0) begin
        n_checks++; if (e !== 16'(33023 + BIAS)) $display("FAIL rows_model_sanity: got %h want %h", e, 16'(33023 + BIAS)); else n_pass++;
      end
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), e);
      wait_valid(1'b0, lat);
      n_checks++; if (lat != 5) $display("FAIL rows_latency: got %0d want 5", lat); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (bus.out_product !== e) $display("FAIL rows_product_%0d: got %h want %h", n, bus.out_product, e); else n_pass++;
      accept();
      n_checks++; if (op_count !== exp_count) $display("FAIL rows_op_count: got %h want %h", op_count, exp_count); else n_pass++;
    end
    force_rows = 1'b0;
  endtask

  task automatic test_hold();
    int lat;
    logic [7:0] a, b;
    logic [15:0] e;
    a = 8'($urandom_range(1, 255));
    b = 8'($urandom_range(1, 255));
    send(a, b, exp_mul(a, b));
    wait_valid(1'b0, lat);
    e = exp_q.pop_front();
    n_checks++; if (lat != 5) $display("FAIL hold_latency: got %0d want 5", lat); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_x = 8'($urandom_range(0, 255));
      bus.in_y = 8'($urandom_range(0, 255));
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_out_valid: got %b want 1", bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_product !== e) $display("FAIL hold_product: got %h want %h", bus.out_product, e); else n_pass++;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready: got %b want 0", bus.in_ready); else n_pass++;
      n_checks++; if (x !== a || y !== b) $display("FAIL hold_xy: got %h/%h want %h/%h", x, y, a, b); else n_pass++;
    end
    bus.in_valid = 1'b0;
    accept();
    n_checks++; if (op_count !== exp_count) $display("FAIL hold_op_count: got %h want %h", op_count, exp_count); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL hold_released: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send(8'd77, 8'd99, exp_mul(8'd77, 8'd99));
    @(negedge clk);
    @(negedge clk);
    // third accumulate cycle: reset lands on its closing edge
    rst = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b0;
    exp_q.delete();
    exp_count = 16'd0;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (op_count !== exp_count) $display("FAIL rstmid_op_count: got %h want %h", op_count, exp_count); else n_pass++;
    // reset must win over a simultaneous in_valid
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_x = 8'd5; bus.in_y = 8'd6;
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL rst_priority: busy %b in_ready %b want 0/1", busy, bus.in_ready); else n_pass++;
    n_checks++; if (x !== 8'd0) $display("FAIL rst_priority_x: got %h want 0", x); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] a, b;
    logic [15:0] e;
    for (int n = 0; n < 5; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(a, b, exp_mul(a, b));
      wait_valid(1'b0, lat);
      n_checks++; if (lat != 5) $display("FAIL b2b_latency: got %0d want 5", lat); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (bus.out_product !== e) $display("FAIL b2b_product: got %h want %h", bus.out_product, e); else n_pass++;
      accept();
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    end
    n_checks++; if (op_count !== exp_count) $display("FAIL b2b_op_count: got %h want %h", op_count, exp_count); else n_pass++;
  endtask

  task automatic test_wrap();
    int lat;
    logic [15:0] e;
    // Preload the completion counter as if 65535 results had been taken.
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    exp_count = 16'hFFFF;
    send(8'd3, 8'd4, exp_mul(8'd3, 8'd4));
    wait_valid(1'b0, lat);
    e = exp_q.pop_front();
    n_checks++; if (bus.out_product !== e) $display("FAIL wrap_product: got %h want %h", bus.out_product, e); else n_pass++;
    accept();
    n_checks++; if (op_count !== exp_count) $display("FAIL wrap_op_count: got %h want %h", op_count, exp_count); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    force_rows = 1'b0;
    for (int k = 0; k < 4; k++) begin ft[k] = 9'd0; fb[k] = 7'd0; end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_x = 8'd0; bus.in_y = 8'd0;
    test_reset();
    test_zero();
    test_random();
    test_rows_edge();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mul_ha_accum_ctrl.md
MUL_HA_ACCUM_CTRL -- requirements
Module: mul_ha_accum_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have ports in_valid input 1, in_ready output 1, in_x input 8, in_y input 8: operand handshake and operands.
REQ-004 SHALL have ports x output 8, y output 8: registered operands driven to the external approximate 8x8 ha_array multiplier.
REQ-005 SHALL have inputs ha_array_k_b 7 and ha_array_k_t 9 for k = 0..3: the multiplier's combinational row outputs.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_product output 16: result handshake and product.
REQ-007 SHALL have outputs busy 1 (state != IDLE) and op_count 16 (completed-result counter).

Function
REQ-008 SHALL implement FSM states IDLE, ACC, DONE.
REQ-009 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-010 On transfer, SHALL register in_x to x and in_y to y, clear the accumulator, set row index to 0, and enter ACC.
REQ-011 x and y SHALL hold stable from transfer until the next transfer.
REQ-012 Row value SHALL be R_k = ha_array_k_t + (ha_array_k_b << 2), 10 bits, unsigned.
REQ-013 In ACC, each cycle SHALL add R_k << (2k) for the current row index k into a 17-bit accumulator and increment k; after k = 3, SHALL enter DONE.
REQ-014 Latency SHALL be: transfer at edge N, out_valid = 1 after edge N+5 (four ACC cycles, then DONE registration).
REQ-015 In DONE, out_valid SHALL be 1 and out_product SHALL hold the final value stable until out_ready = 1.
REQ-016 out_product SHALL equal the low 16 accumulator bits, saturated to 16'hFFFF when bit 16 is set.
REQ-017 On an edge with out_valid and out_ready both 1, SHALL return to IDLE, increment op_count modulo 2^16 (FFFF -> 0000), and assert in_ready in the following cycle.
REQ-018 in_valid outside IDLE SHALL be ignored, with no effect on state.
REQ-019 out_ready outside DONE SHALL be ignored.
REQ-020 in_x or in_y changing during ACC SHALL have no effect on the result.

Reset
REQ-021 When rst = 1 at an edge, SHALL enter IDLE regardless of state, including mid-ACC and DONE; any in-flight result is discarded.
REQ-022 Reset values SHALL be: in_ready = 1 after reset, out_valid = 0, out_product = 0, x = 0, y = 0, busy = 0, op_count = 0, accumulator = 0, row index = 0.
REQ-023 rst SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-024 With macro MUL_HA_BIAS_COMP_EN defined, the DONE-entry value SHALL be accumulator + 17'd224, then saturated per REQ-016; this compensates mean approximation error.
REQ-025 Without MUL_HA_BIAS_COMP_EN, no bias SHALL be added, and out_product SHALL be the plain saturated accumulator.

Verification
REQ-026 Bench: all ha_array inputs driven from a model of the 8x8 multiplier, x = 8'd0, y = 8'd0 -> out_valid at edge N+5, out_product = 0, op_count = 1.
REQ-027 Bench: ha_array_0_t = 9'h1FF, ha_array_3_b = 7'h7F, other rows 0 -> sum 511 + (508 << 6) = 33023 = 16'h80FF (16'h81DF with bias).
REQ-028 Bench: all rows t = 9'h1FF, b = 7'h7F -> accumulator bit 16 set -> out_product = 16'hFFFF.
REQ-029 Bench: hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_product stable, in_ready = 0, in_valid pulses ignored.
REQ-030 Bench: assert rst at the third ACC cycle -> next cycle in IDLE with in_ready = 1, out_valid = 0, op_count unchanged from reset value 0.
REQ-031 Bench: preload 65535 completions, then one more -> op_count wraps to 0.
